count_display: RTL
==================

# count_display

Display-side companion of the parameterised up-counter. It takes the counter's N-bit binary `count` and drives the two active-low seven-segment digits (tens, units) on the board. Conversion is sequential: a shift-and-add-3 (double-dabble) engine converts one bit per clock whenever the input changes. Registered BCD digits and segment patterns update atomically at the end of each conversion.

## Interface
- `N`, default 6, width of `value`; legal range 1..6 (max 63, two decimal digits). Elaboration-time error outside the range.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `value`  in  N  binary value to display, normally the counter's `count`.
- `busy`  out  1  high while a conversion is in progress (states SHIFT, DONE).
- `done`  out  1  one-cycle pulse on the edge at which the outputs update.
- `tens`  out  4  BCD tens digit currently displayed.
- `ones`  out  4  BCD units digit currently displayed.
- `seg1`  out  7  tens segments, active-low, bit0=a … bit6=g.
- `seg0`  out  7  units segments, same encoding.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if `value` != `shown` (the last converted value), capture `value` into the shift register, clear the BCD accumulator and the iteration counter, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT: each cycle, add 3 to every accumulator digit ≥5, then shift {accumulator, shift register} left by 1. After the N-th iteration, go to DONE.
- DONE: load `tens`, `ones`, `seg1` and `seg0` from the accumulator. Set `shown` to the captured value, pulse `done`, and return to IDLE.
- `value` is ignored outside IDLE. A change made during a conversion is picked up by the IDLE compare that follows, so the display always converges to the latest stable value.
- Segment encoding, active-low, digits 0–9:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Blank = 1111111.
- Accumulator width is 8 bits. Iteration counter width is $clog2(N+1).

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `shown`=0, `tens`=0, `ones`=0, `seg0`=1000000, `seg1`=1000000 (blank with macro), `busy`=0, `done`=0. Reset overrides every state, including a conversion in progress; the partial result is discarded.
- Latency: if the IDLE compare succeeds at edge k, SHIFT edges are k+1..k+N and DONE is edge k+N+1. Outputs and `done` change at k+N+1, and IDLE is re-entered at the same edge.
- `busy` is high from edge k through edge k+N+1, i.e. for N+1 cycles.
- Back-to-back: the earliest next capture is edge k+N+2.
- `value` equal to `shown` after reset (value=0): no conversion, no `done`.
- N=1 legal: one SHIFT cycle.

## Configuration
- `COUNT_DISPLAY_BLANK_EN` defined: leading-zero blanking. `seg1`=1111111 whenever `tens`=0, including the reset value. `tens` still reports 0.
- Undefined: `seg1` always shows its digit; a tens digit of 0 displays as 1000000.

## Structure
- Shared package `display_pkg`:
  - state enum (IDLE, SHIFT, DONE)
  - seven-segment constants SEG_0..SEG_9 and SEG_BLANK
  - BCD digit typedef (logic [3:0]).
- One sub-module, `bcd_to_7seg`: combinational, 4-bit digit in, 7-bit active-low pattern out; digits 10–15 map to SEG_BLANK. It is instantiated twice, and its outputs are registered in DONE.
- FSM, double-dabble datapath and output registers live in `count_display`.

## Test plan
- Reset held 3 cycles with `value`=0, then released → `seg0`=1000000, `seg1`=1000000 (1111111 with macro), `busy`=0, and no `done` pulse ever.
- `value`=42 applied at edge 0 (N=6) → `busy` high edges 0–7; at edge 7 `done`=1, `tens`=4, `ones`=2, `seg1`=0011001, `seg0`=0100100.
- `value`=63, then 0, then 9 → digits 6/3, then 0/0, then 0/9. With the macro, `seg1` is blank for 0 and 9.
- `value` 10 → 25 changed at the third SHIFT cycle → first `done` shows 1/0. The next conversion starts at the edge after DONE, and the second `done` shows 2/5.
- `reset` asserted during SHIFT of value 57 → outputs return to reset values on that edge. After release with `value` still 57, a fresh conversion gives 5/7 N+1 cycles later.
- Sweep `value` 0..63 with N=6 → `tens`/`ones` equal value/10 and value%10 at every `done`, and the segments match the encoding list.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the count display slice.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Active-low patterns, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction applied to one BCD digit before each shift.
    function automatic bcd_t dd_adjust(input bcd_t d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment decoder; non-decimal codes blank.
module bcd_to_7seg
    import display_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    // Digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display.sv
// Sequential binary-to-BCD (double-dabble) converter driving two seven-segment digits.
// Optional macro COUNT_DISPLAY_BLANK_EN enables leading-zero blanking of the tens digit.
module count_display
    import display_pkg::*;
#(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] value,
    output logic         busy,
    output logic         done,
    output bcd_t         tens,
    output bcd_t         ones,
    output logic [6:0]   seg1,
    output logic [6:0]   seg0
);

    localparam int CW = $clog2(N + 1);

`ifdef COUNT_DISPLAY_BLANK_EN
    localparam logic [6:0] SEG1_RST = SEG_BLANK;
`else
    localparam logic [6:0] SEG1_RST = SEG_0;
`endif

    if (N < 1 || N > 6) begin : g_bad_n
        $error("count_display: N must be in 1..6");
    end

    state_t          state_r;
    state_t          state_s;
    logic [N-1:0]    sr_r;
    logic [N-1:0]    cap_r;
    logic [N-1:0]    shown_r;
    logic [7:0]      acc_r;
    logic [CW-1:0]   cnt_r;
    logic [7:0]      adj_s;
    logic            last_s;
    logic [6:0]      seg_tens_s;
    logic [6:0]      seg_ones_s;
    logic [6:0]      seg1_s;

    bcd_to_7seg u_tens (.digit(acc_r[7:4]), .seg(seg_tens_s));
    bcd_to_7seg u_ones (.digit(acc_r[3:0]), .seg(seg_ones_s));

    // Next-state logic and combinational datapath helpers
    always_comb begin
        state_s = state_r;
        last_s  = (cnt_r == CW'(N - 1));
        adj_s   = {dd_adjust(acc_r[7:4]), dd_adjust(acc_r[3:0])};
`ifdef COUNT_DISPLAY_BLANK_EN
        if (acc_r[7:4] == 4'd0) begin
            seg1_s = SEG_BLANK;
        end else begin
            seg1_s = seg_tens_s;
        end
`else
        seg1_s = seg_tens_s;
`endif
        case (state_r)
            IDLE: begin
                if (value != shown_r) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Conversion datapath and atomically updated display registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_r    <= {N{1'b0}};
            cap_r   <= {N{1'b0}};
            shown_r <= {N{1'b0}};
            acc_r   <= 8'd0;
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            tens    <= 4'd0;
            ones    <= 4'd0;
            seg1    <= SEG1_RST;
            seg0    <= SEG_0;
        end else begin
            busy <= (state_s != IDLE);
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (value != shown_r) begin
                        sr_r  <= value;
                        cap_r <= value;
                        acc_r <= 8'd0;
                        cnt_r <= {CW{1'b0}};
                    end
                end
                SHIFT: begin
                    acc_r <= {adj_s[6:0], sr_r[N-1]};
                    sr_r  <= sr_r << 1;
                    cnt_r <= cnt_r + CW'(1'b1);
                end
                DONE: begin
                    tens    <= acc_r[7:4];
                    ones    <= acc_r[3:0];
                    seg1    <= seg1_s;
                    seg0    <= seg_ones_s;
                    shown_r <= cap_r;
                    done    <= 1'b1;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule
